// File: rtl/hms_display_scan_pkg.sv
// Shared constants for the HH:MM:SS multiplexed seven-segment display scanner.
// Segment encodings are active-low {g,f,e,d,c,b,a}; digit enables are active-low.
package hms_display_scan_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // BCD constants
  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Active-low seven-segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_0    = 7'h40;
  localparam logic [6:0] SEG7_1    = 7'h79;
  localparam logic [6:0] SEG7_2    = 7'h24;
  localparam logic [6:0] SEG7_3    = 7'h30;
  localparam logic [6:0] SEG7_4    = 7'h19;
  localparam logic [6:0] SEG7_5    = 7'h12;
  localparam logic [6:0] SEG7_6    = 7'h02;
  localparam logic [6:0] SEG7_7    = 7'h78;
  localparam logic [6:0] SEG7_8    = 7'h00;
  localparam logic [6:0] SEG7_9    = 7'h10;
  localparam logic [6:0] SEG7_DASH = 7'h3F;

  // All segments (including dp) dark, all digits disabled
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] AN_OFF  = 6'h3F;

  // Digit slot index; the enum value is also the an[] bit position
  typedef enum logic [2:0] {
    DIG_SEC0  = 3'd0,
    DIG_SEC1  = 3'd1,
    DIG_MIN0  = 3'd2,
    DIG_MIN1  = 3'd3,
    DIG_HOUR0 = 3'd4,
    DIG_HOUR1 = 3'd5
  } digit_e;

endpackage

// File: rtl/hms_display_scan_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; values above 9 show a dash.
import hms_display_scan_pkg::*;

module bcd_to_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup, dash for anything outside 0-9
  always_comb begin
    seg = SEG7_DASH;
    case (bcd)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/hms_display_scan.sv
// Six-digit multiplexed display scanner for an HH:MM:SS clock.
// Each digit slot lasts SCAN_DIV clk cycles; the six inputs are snapshotted once
// per frame (on the tick leaving slot 5) so a frame never tears. seg/an are
// registered, an is blanked for one cycle after every slot change, and dp acts
// as the colon on min0 and hour0.
// Build option: define LZB_EN to blank the hour1 digit when it is zero.
import hms_display_scan_pkg::*;

module hms_display_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec0,
  input  logic [3:0] sec1,
  input  logic [3:0] min0,
  input  logic [3:0] min1,
  input  logic [3:0] hour0,
  input  logic [3:0] hour1,
  output logic [7:0] seg,
  output logic [5:0] an,
  output logic       frame_start
);

  logic [15:0]                 presc;
  logic                        tick;
  digit_e                      idx;
  logic [NUM_DIGITS-1:0][3:0]  snap;
  logic [3:0]                  cur_bcd;
  logic [6:0]                  cur_seg7;
  logic                        dp_n;
  logic [5:0]                  an_sel;
  logic [7:0]                  seg_d;
  logic [5:0]                  an_d;

  assign tick = (presc == 16'(SCAN_DIV - 1));

  // Prescaler: counts 0..SCAN_DIV-1 and wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 16'd1;
  end

  // Digit index advances once per slot, 5 wraps to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx <= DIG_SEC0;
    else if (tick)
      idx <= (idx == DIG_HOUR1) ? DIG_SEC0 : digit_e'(idx + 3'd1);
  end

  // Frame snapshot of all six digits, taken when leaving the last slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (idx == DIG_HOUR1);
      if (tick && (idx == DIG_HOUR1))
        snap <= {hour1, hour0, min1, min0, sec1, sec0};
    end
  end

  // Select the snapshot digit and digit enable for the current slot
  always_comb begin
    cur_bcd = BCD_ZERO;
    an_sel  = AN_OFF;
    case (idx)
      DIG_SEC0:  begin cur_bcd = snap[0]; an_sel = 6'b111110; end
      DIG_SEC1:  begin cur_bcd = snap[1]; an_sel = 6'b111101; end
      DIG_MIN0:  begin cur_bcd = snap[2]; an_sel = 6'b111011; end
      DIG_MIN1:  begin cur_bcd = snap[3]; an_sel = 6'b110111; end
      DIG_HOUR0: begin cur_bcd = snap[4]; an_sel = 6'b101111; end
      DIG_HOUR1: begin cur_bcd = snap[5]; an_sel = 6'b011111; end
      default:   begin cur_bcd = BCD_ZERO; an_sel = AN_OFF; end
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg7)
  );

  // Next seg/an: colon dp, ghost blanking on tick, optional leading-zero blanking
  always_comb begin
    dp_n  = !((idx == DIG_MIN0) || (idx == DIG_HOUR0));
    seg_d = {dp_n, cur_seg7};
    an_d  = tick ? AN_OFF : an_sel;
`ifdef LZB_EN
    if ((idx == DIG_HOUR1) && (snap[5] == BCD_ZERO)) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end
`else
`endif
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_hms_display_scan.sv
// Self-checking bench for hms_display_scan with SCAN_DIV=4. The reference model
// derives slot, tick and frame boundaries arithmetically from the number of
// clock edges since reset release and keeps its own copy of the frame snapshot.
module tb_hms_display_scan;

  localparam int D = 4;
  localparam int FRAME = 6 * D;

  logic       clk;
  logic       rst;
  logic [3:0] din [6];
  logic [7:0] seg;
  logic [5:0] an;
  logic       frame_start;

  int         n_checks;
  int         n_fail;
  int         t;
  int         last_fs;
  logic [3:0] msnap [6];

  hms_display_scan #(.SCAN_DIV(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .sec0        (din[0]),
    .sec1        (din[1]),
    .min0        (din[2]),
    .min1        (din[3]),
    .hour0       (din[4]),
    .hour1       (din[5]),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg7(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                          input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    din[5] = h1; din[4] = h0; din[3] = m1; din[2] = m0; din[1] = s1; din[0] = s0;
  endtask

  // One clock: predict outputs after this edge, then compare on the falling edge
  task automatic step();
    int         p;
    int         ip;
    logic       tk;
    logic [7:0] es;
    logic [5:0] ea;
    logic       ef;
    @(posedge clk);
    t++;
    p  = t - 1;
    ip = (p / D) % 6;
    tk = ((p % D) == D - 1);
    ea = tk ? 6'h3F : ~(6'b000001 << ip);
    es = {((ip == 2) || (ip == 4)) ? 1'b0 : 1'b1, ref_seg7(msnap[ip])};
`ifdef LZB_EN
    if ((ip == 5) && (msnap[5] == 4'd0)) begin
      es = 8'hFF;
      ea = 6'h3F;
    end
`endif
    ef = ((t % FRAME) == 0);
    if (ef)
      for (int i = 0; i < 6; i++) msnap[i] = din[i];
    @(negedge clk);
    check_eq("seg", 32'(seg), 32'(es));
    check_eq("an", 32'(an), 32'(ea));
    check_eq("frame_start", 32'(frame_start), 32'(ef));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check_eq("frame_period", t - last_fs, FRAME);
      last_fs = t;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_async_seg", 32'(seg), 32'h0FF);
    check_eq("rst_async_an", 32'(an), 32'h03F);
    check_eq("rst_async_fs", 32'(frame_start), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_held_seg", 32'(seg), 32'h0FF);
    check_eq("rst_held_an", 32'(an), 32'h03F);
    rst = 1'b0;
    t = 0;
    last_fs = -1;
    for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
  endtask

  initial begin
    int   found;
    logic [3:0] r [6];
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_fail = 0;
    t = 0;
    last_fs = -1;
    for (int i = 0; i < 6; i++) begin din[i] = 4'd0; msnap[i] = 4'd0; end

    // Power-up, then 23:59:58 held: first frame zeros, second shows live value
    do_reset();
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
    run(2 * FRAME + 2);

    // 12:34:56 changing to :57 mid-frame
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    run(FRAME + 9);
    din[0] = 4'd7;
    run(2 * FRAME);

    // Invalid digit on sec1 shows a dash only there
    set_time(4'd1, 4'd4, 4'd0, 4'd9, 4'hC, 4'd3);
    run(2 * FRAME);

    // Leading zero on hour1
    set_time(4'd0, 4'd4, 4'd2, 4'd7, 4'd1, 4'd0);
    run(2 * FRAME);

    // Random digits, mostly legal BCD, changing at random points
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 6; i++)
        r[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) r[5] = 4'd0;
      for (int i = 0; i < 6; i++) din[i] = r[i];
      run($urandom_range(1, 30));
    end

    // Reset in the middle of slot 3 (prescaler=2)
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (((t % D) == 2) && (((t / D) % 6) == 3)) found = 1;
      else step();
    end
    check_eq("rst_point_reached", found, 1);
    check_eq("pre_rst_an", 32'(an), 32'h037);
    do_reset();
    set_time(4'd0, 4'd9, 4'd1, 4'd5, 4'd2, 4'd6);
    run(2 * FRAME + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
